// File: rtl/fmac_pkg.sv
// fmac_pkg: shared types and constants for the dot-product sequencer.
// Float 1.0, FSM state encoding and lane-index width.
package fmac_pkg;
  localparam logic [31:0] FP_ONE = 32'h3F80_0000;
  localparam int PSUMS_DFLT = 4;
  localparam int LANE_W = $clog2(PSUMS_DFLT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_REDUCE,
    S_FIN
  } state_t;
endpackage

// File: rtl/fmac_dot_seq_if.sv
// fmac_dot_seq_if: valid/data link to the shared multiply-add float unit.
// master = sequencer side, slave = float unit side.
interface fmac_dot_seq_if #(
  parameter int XLEN = 32
);
  logic            float_a_valid;
  logic [XLEN-1:0] float_a_data;
  logic            float_b_valid;
  logic [XLEN-1:0] float_b_data;
  logic [XLEN-1:0] float_c_data;
  logic            float_result_valid;
  logic [XLEN-1:0] float_result;

  modport master (
    output float_a_valid, float_a_data,
    output float_b_valid, float_b_data,
    output float_c_data,
    input  float_result_valid, float_result
  );

  modport slave (
    input  float_a_valid, float_a_data,
    input  float_b_valid, float_b_data,
    input  float_c_data,
    output float_result_valid, float_result
  );
endinterface

// File: rtl/fmac_tag_fifo.sv
// fmac_tag_fifo: small synchronous FIFO of lane tags for in-flight ops.
// Push and pop may happen in the same cycle.
module fmac_tag_fifo
  import fmac_pkg::*;
#(
  parameter int DEPTH = PSUMS_DFLT,
  parameter int W     = LANE_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_dout  = r_mem[r_rp];

  // pointer/count update and storage write
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/fmac_dot_seq.sv
// fmac_dot_seq: dot product over the shared a*b+c float unit.
// Interleaves PSUMS partial-sum lanes, then folds them into lane 0.
module fmac_dot_seq
  import fmac_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11,
  parameter int PSUMS  = PSUMS_DFLT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [ADDR_W-1:0] a_base_i,
  input  logic [ADDR_W-1:0] b_base_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [XLEN-1:0]   result_o,
  output logic              err_o,
  output logic              a_rd_en_o,
  output logic [ADDR_W-1:0] a_rd_addr_o,
  input  logic [XLEN-1:0]   a_rd_data_i,
  output logic              b_rd_en_o,
  output logic [ADDR_W-1:0] b_rd_addr_o,
  input  logic [XLEN-1:0]   b_rd_data_i,
  fmac_dot_seq_if.master    fu
);
  localparam int LW = $clog2(PSUMS);

  state_t            r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_abase;
  logic [ADDR_W-1:0] r_bbase;
  logic [XLEN-1:0]   r_lane [PSUMS];
  logic [PSUMS-1:0]  r_busy;
  logic              r_iss_v;
  logic [LW-1:0]     r_iss_lane;
  logic              r_red_v;
  logic [LW:0]       r_k;

  logic [LW-1:0]     w_lane;
  logic              w_issue;
  logic              w_push;
  logic [LW-1:0]     w_push_tag;
  logic [LW-1:0]     w_tag;
  logic              w_full;
  logic              w_empty;
  logic              w_retire;
  logic              w_pop_err;
  logic [LEN_W-1:0]  w_kmax;

  assign w_lane  = r_idx[LW-1:0];
  assign w_issue = (r_state == S_ISSUE) && (r_idx < r_len)
                && !r_busy[w_lane] && !w_full;

  assign a_rd_en_o   = w_issue;
  assign b_rd_en_o   = w_issue;
  assign a_rd_addr_o = w_issue ? r_abase + ADDR_W'(r_idx) : '0;
  assign b_rd_addr_o = w_issue ? r_bbase + ADDR_W'(r_idx) : '0;

  assign w_push     = r_iss_v | r_red_v;
  assign w_push_tag = r_iss_v ? r_iss_lane : '0;
  assign w_retire   = fu.float_result_valid && !w_empty;
  assign w_pop_err  = fu.float_result_valid && w_empty;
  assign w_kmax     = (r_len < LEN_W'(PSUMS)) ? r_len : LEN_W'(PSUMS);

  assign fu.float_a_valid = w_push;
  assign fu.float_b_valid = w_push;
  assign fu.float_a_data  = r_iss_v ? a_rd_data_i
                          : r_red_v ? r_lane[r_k[LW-1:0]] : '0;
  assign fu.float_b_data  = r_iss_v ? b_rd_data_i
                          : r_red_v ? XLEN'(FP_ONE) : '0;
  assign fu.float_c_data  = r_iss_v ? r_lane[r_iss_lane]
                          : r_red_v ? r_lane[0] : '0;

  fmac_tag_fifo #(
    .DEPTH (PSUMS),
    .W     (LW)
  ) u_tag_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_push  (w_push),
    .i_din   (w_push_tag),
    .i_pop   (fu.float_result_valid),
    .o_dout  (w_tag),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // sequencer FSM with lane retire and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_idx      <= '0;
      r_abase    <= '0;
      r_bbase    <= '0;
      r_busy     <= '0;
      r_iss_v    <= 1'b0;
      r_iss_lane <= '0;
      r_red_v    <= 1'b0;
      r_k        <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= '0;
      err_o      <= 1'b0;
      for (int i = 0; i < PSUMS; i++)
        r_lane[i] <= '0;
    end else begin
      done_o     <= 1'b0;
      r_iss_v    <= w_issue;
      r_iss_lane <= w_lane;
      r_red_v    <= 1'b0;

      if (w_retire) begin
        r_lane[w_tag] <= fu.float_result;
        r_busy[w_tag] <= 1'b0;
        if (r_state == S_REDUCE)
          r_k <= r_k + 1'b1;
      end

      if (w_issue) begin
        r_busy[w_lane] <= 1'b1;
        r_idx          <= r_idx + 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_len   <= len_i;
            r_abase <= a_base_i;
            r_bbase <= b_base_i;
            r_idx   <= '0;
            r_k     <= (LW+1)'(1);
            r_busy  <= '0;
            err_o   <= 1'b0;
            busy_o  <= 1'b1;
            for (int i = 0; i < PSUMS; i++)
              r_lane[i] <= '0;
            r_state <= (len_i == '0) ? S_FIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_idx == r_len)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_busy == '0 && !r_iss_v) begin
            r_k     <= (LW+1)'(1);
            r_state <= S_REDUCE;
          end
        end
        S_REDUCE: begin
          if (!r_busy[0] && !r_red_v) begin
            if (LEN_W'(r_k) < w_kmax) begin
              r_busy[0] <= 1'b1;
              r_red_v   <= 1'b1;
            end else begin
              r_state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          result_o <= r_lane[0];
          done_o   <= 1'b1;
          busy_o   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_pop_err)
        err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fmac_dot_seq.sv
// tb_fmac_dot_seq: directed vectors plus reset/ignore-start sequences.
// Float unit and operand buffers are modelled here.
module tb_fmac_dot_seq;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 11;
  localparam int PSUMS  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len_in;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic              busy;
  logic              done;
  logic [XLEN-1:0]   result;
  logic              err;
  logic              a_rd_en;
  logic [ADDR_W-1:0] a_rd_addr;
  logic [XLEN-1:0]   a_rd_data;
  logic              b_rd_en;
  logic [ADDR_W-1:0] b_rd_addr;
  logic [XLEN-1:0]   b_rd_data;

  always #5 clk = ~clk;

  fmac_dot_seq_if #(.XLEN(XLEN)) fu();

  fmac_dot_seq #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .PSUMS(PSUMS)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .start_i     (start),
    .len_i       (len_in),
    .a_base_i    (a_base),
    .b_base_i    (b_base),
    .busy_o      (busy),
    .done_o      (done),
    .result_o    (result),
    .err_o       (err),
    .a_rd_en_o   (a_rd_en),
    .a_rd_addr_o (a_rd_addr),
    .a_rd_data_i (a_rd_data),
    .b_rd_en_o   (b_rd_en),
    .b_rd_addr_o (b_rd_addr),
    .b_rd_data_i (b_rd_data),
    .fu          (fu)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // nonnegative integer <-> single precision, enough for the test data
  function automatic int f2i(logic [31:0] f);
    int e;
    logic [23:0] m;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    if (e < 0 || e > 23) return 0;
    m = {1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [31:0] i2f(int v);
    int e;
    logic [31:0] u;
    if (v <= 0) return 32'h0;
    e = 0;
    for (int i = 0; i < 24; i++) if (v[i]) e = i;
    u = v;
    u = u << (23 - e);
    return {1'b0, 8'(e + 127), u[22:0]};
  endfunction

  // operand buffers: data one cycle after the strobe
  logic [XLEN-1:0] mem_a [1024];
  logic [XLEN-1:0] mem_b [1024];
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
    if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];
  end

  // float unit model and monitors, all at the negative edge
  int              cyc = 0;
  int              lat = 1;
  logic [31:0]     q_res [$];
  int              q_due [$];
  int              max_out, n_issue, n_rd, n_done, addr_bad, mon_n;
  int              vbad = 0;
  logic [ADDR_W-1:0] mon_ab, mon_bb;

  always @(negedge clk) begin
    cyc++;
    if (fu.float_a_valid) begin
      q_res.push_back(i2f(f2i(fu.float_a_data) * f2i(fu.float_b_data)
                          + f2i(fu.float_c_data)));
      q_due.push_back(cyc + lat);
      n_issue++;
    end
    if (fu.float_b_valid != fu.float_a_valid) vbad++;
    if (q_res.size() > max_out) max_out = q_res.size();
    fu.float_result_valid = 1'b0;
    fu.float_result = '0;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      fu.float_result_valid = 1'b1;
      fu.float_result = q_res.pop_front();
      void'(q_due.pop_front());
    end
    if (a_rd_en) begin
      if (a_rd_addr != mon_ab + ADDR_W'(mon_n) || !b_rd_en
          || b_rd_addr != mon_bb + ADDR_W'(mon_n))
        addr_bad++;
      mon_n++;
      n_rd++;
    end
    if (done) n_done++;
  end

  typedef struct {
    int          len;
    int          ab;
    int          bb;
    int          lat;
    bit          ramp;
    int          bval;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [8];

  task automatic fill(input vec_t v);
    for (int i = 0; i < v.len; i++) begin
      mem_a[(v.ab + i) % 1024] = v.ramp ? i2f(i + 1) : i2f(1);
      mem_b[(v.bb + i) % 1024] = i2f(v.bval);
    end
  endtask

  task automatic arm(input int ab, input int bb, input int l);
    lat = l;
    mon_ab = ADDR_W'(ab);
    mon_bb = ADDR_W'(bb);
    mon_n = 0;
    n_rd = 0;
    n_done = 0;
    n_issue = 0;
    max_out = 0;
    addr_bad = 0;
  endtask

  task automatic wait_done(output logic [31:0] res, output bit to);
    to = 1'b1;
    res = '0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        res = result;
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_job(input vec_t v, output logic [31:0] res,
                         output bit to);
    fill(v);
    arm(v.ab, v.bb, v.lat);
    @(negedge clk);
    len_in = LEN_W'(v.len);
    a_base = ADDR_W'(v.ab);
    b_base = ADDR_W'(v.bb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(res, to);
  endtask

  initial begin
    logic [31:0] res;
    bit          to;
    int          nexp;

    vt[0] = '{4,    0,    0,  3, 1'b1, 1, 32'h4120_0000};
    vt[1] = '{16,   0,    0,  1, 1'b0, 1, 32'h4180_0000};
    vt[2] = '{16,   0,    0, 12, 1'b0, 1, 32'h4180_0000};
    vt[3] = '{1,    0,    0,  2, 1'b1, 3, 32'h4040_0000};
    vt[4] = '{4, 1022, 1023,  3, 1'b1, 2, 32'h41A0_0000};
    vt[5] = '{3,    0,    0,  2, 1'b1, 1, 32'h40C0_0000};
    vt[6] = '{8,    0,  512,  5, 1'b1, 1, 32'h4210_0000};
    vt[7] = '{5,    0,    0,  1, 1'b1, 2, 32'h41F0_0000};

    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    rst_n = 1'b0;
    start = 1'b0;
    len_in = '0;
    a_base = '0;
    b_base = '0;
    arm(0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", result, 0);
    check("rst_err", 32'(err), 0);
    check("rst_rd_en", 32'({a_rd_en, b_rd_en}), 0);
    check("rst_fvalid", 32'(fu.float_a_valid), 0);
    rst_n = 1'b1;

    // table-driven jobs
    for (int t = 0; t < 8; t++) begin
      run_job(vt[t], res, to);
      nexp = vt[t].len + ((vt[t].len < PSUMS) ? vt[t].len : PSUMS) - 1;
      check($sformatf("v%0d_timeout", t), 32'(to), 0);
      check($sformatf("v%0d_result", t), res, vt[t].exp);
      check($sformatf("v%0d_done_cnt", t), n_done, 1);
      check($sformatf("v%0d_err", t), 32'(err), 0);
      check($sformatf("v%0d_addr", t), addr_bad, 0);
      check($sformatf("v%0d_reads", t), n_rd, vt[t].len);
      check($sformatf("v%0d_issues", t), n_issue, nexp);
      check($sformatf("v%0d_outstanding", t), 32'(max_out <= PSUMS), 1);
      check($sformatf("v%0d_busy_end", t), 32'(busy), 0);
    end

    // len == 0: straight to FIN, no strobes
    arm(0, 0, 1);
    @(negedge clk);
    len_in = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("len0_busy", 32'(busy), 1);
    check("len0_done_early", 32'(done), 0);
    @(posedge clk);
    #1;
    check("len0_done", 32'(done), 1);
    check("len0_result", result, 0);
    check("len0_busy_off", 32'(busy), 0);
    @(posedge clk);
    #1;
    check("len0_done_pulse", 32'(done), 0);
    repeat (3) @(negedge clk);
    check("len0_reads", n_rd, 0);
    check("len0_issues", n_issue, 0);

    // start during a job is ignored
    fill(vt[6]);
    for (int i = 0; i < 4; i++) begin
      mem_a[200 + i] = i2f(7);
      mem_b[200 + i] = i2f(7);
    end
    arm(0, 512, 5);
    @(negedge clk);
    len_in = LEN_W'(8);
    a_base = '0;
    b_base = ADDR_W'(512);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    len_in = LEN_W'(4);
    a_base = ADDR_W'(200);
    b_base = ADDR_W'(200);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(res, to);
    check("ign_timeout", 32'(to), 0);
    check("ign_result", res, 32'h4210_0000);
    check("ign_reads", n_rd, 8);
    check("ign_addr", addr_bad, 0);
    check("ign_done_cnt", n_done, 1);
    check("ign_err", 32'(err), 0);

    // reset mid-ISSUE with results outstanding
    fill(vt[6]);
    arm(0, 512, 12);
    @(negedge clk);
    len_in = LEN_W'(8);
    a_base = '0;
    b_base = ADDR_W'(512);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (q_res.size() >= 2) begin
        to = 1'b0;
        break;
      end
    end
    check("rstmid_reached", 32'(to), 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_done", 32'(done), 0);
    check("rstmid_result", result, 0);
    check("rstmid_err", 32'(err), 0);
    check("rstmid_fvalid", 32'(fu.float_a_valid), 0);
    to = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (q_res.size() == 0) begin
        to = 1'b0;
        break;
      end
    end
    repeat (2) @(negedge clk);
    check("rstmid_drain", 32'(to), 0);
    check("rstmid_late_err", 32'(err), 1);
    check("rstmid_idle", 32'(busy), 0);
    run_job(vt[0], res, to);
    check("post_rst_timeout", 32'(to), 0);
    check("post_rst_result", res, 32'h4120_0000);
    check("post_rst_err", 32'(err), 0);
    check("post_rst_done_cnt", n_done, 1);

    check("b_valid_tracks_a", vbad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
